// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the dff_wr_arbiter block.
//   state_t : arbiter FSM state (IDLE, HOLD)
//   idx_w() : index width for a requester count; never below 1 bit
package dff_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req    : effective request vector
//   ptr    : last granted index; the search starts at ptr+1 and wraps
//   any    : at least one request present
//   winner : first requester found at or after ptr+1
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   winner
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                start;
  int                off;

  // Duplicate the vector and shift, so the start position lands at bit 0.
  // The lowest set bit of the rotated view is the round-robin winner.
  always_comb begin
    start  = (int'(ptr) + 1) % NREQ;
    dbl    = {req, req} >> start;
    rot    = dbl[NREQ-1:0];
    off    = 0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (rot[i]) off = i;
    any    = |req;
    winner = IW'((off + start) % NREQ);
  end

endmodule

// File: rtl/dff_wr_arbiter.sv
// Round-robin write arbiter for a shared holding register.
//   clk, rst  : clock, async active-high reset
//   req       : per-requester level request, held until its ack
//   din       : flattened data, requester i at [i*WIDTH +: WIDTH]
//   ack       : one-hot one-cycle pulse, write of requester i captured
//   dout      : holding register
//   dout_vld  : one-cycle pulse with ack, marks new dout
//   gnt_id    : most recently granted requester
//   busy      : high while holding after a write
module dff_wr_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_vld,
  output logic [idx_w(NREQ)-1:0] gnt_id,
  output logic                  busy
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(HOLD_CYC) + 1;

  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("dff_wr_arbiter: HOLD_CYC must be at least 1");
  end
  if (NREQ < 2) begin : g_bad_nreq
    $error("dff_wr_arbiter: NREQ must be at least 2");
  end

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] eff;
  logic            any;
  logic [IW-1:0]   winner;
  logic            elig;

  // A requester still seeing its ack has not had a chance to drop req yet.
  assign eff  = req & ~ack;
  assign elig = (state == IDLE) || (cnt == '0);
  assign busy = (state == HOLD);

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (eff),
    .ptr    (ptr),
    .any    (any),
    .winner (winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= IW'(NREQ - 1);
      ack      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      gnt_id   <= '0;
    end else if (elig) begin
      if (any) begin
        state    <= HOLD;
        cnt      <= CW'(HOLD_CYC - 1);
        ptr      <= winner;
        gnt_id   <= winner;
        ack      <= NREQ'(1) << winner;
        dout     <= din[winner*WIDTH +: WIDTH];
        dout_vld <= 1'b1;
      end else begin
        state    <= IDLE;
        ack      <= '0;
        dout_vld <= 1'b0;
      end
    end else begin
      cnt      <= cnt - 1'b1;
      ack      <= '0;
      dout_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dff_wr_arbiter.sv
// Bench for dff_wr_arbiter: two instances (HOLD_CYC=2 and HOLD_CYC=1) share
// the same stimulus; each is compared every edge against a reference model
// that tracks edges-since-grant and searches requesters in rotation order.
module tb_dff_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] din = '0;

  logic [NREQ-1:0]  ack2,  ack1;
  logic [WIDTH-1:0] dout2, dout1;
  logic             vld2,  vld1;
  logic [1:0]       gnt2,  gnt1;
  logic             busy2, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dff_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYC(2)) u_dut_h2 (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .ack(ack2), .dout(dout2), .dout_vld(vld2), .gnt_id(gnt2), .busy(busy2)
  );

  dff_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYC(1)) u_dut_h1 (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .ack(ack1), .dout(dout1), .dout_vld(vld1), .gnt_id(gnt1), .busy(busy1)
  );

  // reference model state, index 0 -> HOLD_CYC=2, index 1 -> HOLD_CYC=1
  logic [NREQ-1:0]  m_ack  [2];
  logic [WIDTH-1:0] m_dout [2];
  bit               m_vld  [2];
  bit               m_idle [2];
  int               m_ptr  [2];
  int               m_since[2];
  int               m_gnt  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_ack[i]   = '0;
    m_dout[i]  = '0;
    m_vld[i]   = 0;
    m_idle[i]  = 1;
    m_ptr[i]   = NREQ - 1;
    m_since[i] = 0;
    m_gnt[i]   = 0;
  endtask

  task automatic model_edge(input int i, input int hold);
    logic [NREQ-1:0] eff;
    int w;
    eff = req & ~m_ack[i];
    m_ack[i] = '0;
    m_vld[i] = 0;
    if (m_idle[i] || m_since[i] >= hold) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && eff[(m_ptr[i] + k) % NREQ]) w = (m_ptr[i] + k) % NREQ;
      if (w >= 0) begin
        m_ack[i][w] = 1'b1;
        m_vld[i]    = 1;
        m_dout[i]   = din[w*WIDTH +: WIDTH];
        m_gnt[i]    = w;
        m_ptr[i]    = w;
        m_since[i]  = 1;
        m_idle[i]   = 0;
      end else begin
        m_idle[i] = 1;
      end
    end else begin
      m_since[i]++;
    end
  endtask

  task automatic compare_all();
    chk("h2.ack",  32'(ack2),  32'(m_ack[0]));
    chk("h2.dout", 32'(dout2), 32'(m_dout[0]));
    chk("h2.vld",  32'(vld2),  32'(m_vld[0]));
    chk("h2.gnt",  32'(gnt2),  32'(m_gnt[0]));
    chk("h2.busy", 32'(busy2), 32'(!m_idle[0]));
    chk("h1.ack",  32'(ack1),  32'(m_ack[1]));
    chk("h1.dout", 32'(dout1), 32'(m_dout[1]));
    chk("h1.vld",  32'(vld1),  32'(m_vld[1]));
    chk("h1.gnt",  32'(gnt1),  32'(m_gnt[1]));
    chk("h1.busy", 32'(busy1), 32'(!m_idle[1]));
  endtask

  // one clock: model update at the edge, compare 1ns later, return at negedge
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      if (rst) model_reset(i);
      else     model_edge(i, (i == 0) ? 2 : 1);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  // synchronous-style reset pulse used between scenarios
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    #1;
    model_reset(0);
    model_reset(1);
    step();
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    int seq[5];
    for (int i = 0; i < 2; i++) model_reset(i);

    // reset state
    #2;
    compare_all();
    @(negedge clk);
    step();
    rst = 1'b0;

    // single requester on index 2, held continuously
    din[2*WIDTH +: WIDTH] = 8'hA5;
    req = 4'b0100;
    pulses = 0;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (ack2[2]) pulses++;
      if (e == 1) chk("single.first_ack", 32'(ack2), 32'h4);
      if (e == 2) chk("single.busy_mid",  32'(busy2), 32'h1);
    end
    chk("single.pulses", 32'(pulses), 32'd3);
    chk("single.dout",   32'(dout2),  32'hA5);

    // async reset right after a write of 0x3C
    do_reset();
    din[0 +: WIDTH] = 8'h3C;
    req = 4'b0001;
    step();
    chk("areset.pre_dout", 32'(dout2), 32'h3C);
    req = '0;
    #2;
    rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    chk("areset.dout", 32'(dout2), 32'h0);
    chk("areset.busy", 32'(busy2), 32'h0);
    chk("areset.gnt",  32'(gnt2),  32'h0);
    compare_all();
    step();
    rst = 1'b0;

    // fairness on HOLD_CYC=1 with all requesting
    req = 4'b1111;
    for (int e = 0; e < 5; e++) begin
      step();
      seq[e] = int'(gnt1);
    end
    chk("fair.g0", 32'(seq[0]), 32'd0);
    chk("fair.g1", 32'(seq[1]), 32'd1);
    chk("fair.g2", 32'(seq[2]), 32'd2);
    chk("fair.g3", 32'(seq[3]), 32'd3);
    chk("fair.g4", 32'(seq[4]), 32'd0);

    // double-grant guard on HOLD_CYC=1: req[1] dropped one cycle after ack
    do_reset();
    req = 4'b0010;
    pulses = 0;
    step(); if (ack1[1]) pulses++;
    step(); if (ack1[1]) pulses++;
    req = '0;
    step(); if (ack1[1]) pulses++;
    step(); if (ack1[1]) pulses++;
    chk("dgrant.pulses", 32'(pulses), 32'd1);

    // rotation: after grant to 1, requesters 0 and 3 together -> 3 then 0
    req = 4'b1001;
    step();
    chk("rot.first",  32'(gnt1), 32'd3);
    step();
    chk("rot.second", 32'(gnt1), 32'd0);
    req = '0;
    step();

    // reset mid-HOLD, release with req[1] and req[3] high
    do_reset();
    req = 4'b0100;
    step();
    chk("midhold.gnt", 32'(gnt2), 32'd2);
    rst = 1'b1;
    req = 4'b1010;
    #1;
    model_reset(0);
    model_reset(1);
    chk("midhold.dout", 32'(dout2), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("midhold.first", 32'(gnt2), 32'd1);

    // randomized traffic with occasional resets
    for (int e = 0; e < 400; e++) begin
      req = NREQ'($urandom);
      din = (NREQ*WIDTH)'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      if (rst) begin
        #1;
        model_reset(0);
        model_reset(1);
        compare_all();
      end
      step();
    end
    rst = 1'b0;
    req = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dff_wr_arbiter.md
# dff_wr_arbiter

Round-robin write arbiter and sequencer for a shared WIDTH-bit D-flip-flop holding register. NREQ requesters compete to load the register. The block grants one requester per eligible clock edge, captures its data, and acknowledges it with a one-cycle pulse. After each write it holds the register stable for HOLD_CYC cycles before it grants again. It sits between the requesting agents and the downstream consumer of the registered value.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, data width of the holding register
- HOLD_CYC, 2, cycles the register is held after a write (minimum 1)
- clk  input  1  clock, all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  request per requester; level, held until its ack is seen
- din  input  NREQ*WIDTH  flattened data; requester i occupies bits [i*WIDTH +: WIDTH]
- ack  output  NREQ  one-hot, one-cycle pulse: the write of requester i was captured
- dout  output  WIDTH  holding register contents
- dout_vld  output  1  one-cycle pulse, coincident with ack, marks a new dout value
- gnt_id  output  $clog2(NREQ)  index of the most recently granted requester
- busy  output  1  high while in HOLD

## Operation
- States:
  - IDLE: no write in progress.
  - HOLD: a down-counter cnt (width $clog2(HOLD_CYC)+1) runs.
- Eligible edge: a posedge where state==IDLE, or state==HOLD and cnt==0.
- Masked request: effective req = req & ~ack. A requester whose ack is currently high is never re-granted on that edge.
- On an eligible edge with any effective req:
  - The winner is chosen round-robin: search starts at ptr+1, wraps modulo NREQ, and takes the first effective req.
  - dout <= din[winner]; ack[winner] <= 1; dout_vld <= 1; gnt_id <= winner; ptr <= winner.
  - cnt <= HOLD_CYC-1; state <= HOLD.
- On an eligible edge with no effective req: state <= IDLE; ack, dout_vld <= 0.
- HOLD with cnt!=0: cnt decrements; ack and dout_vld are 0; dout is unchanged.
- A requester that keeps req high after its ack is a new request. It competes again at the next eligible edge.
- din of non-winners is ignored. din of the winner is sampled only at its grant edge.

## Timing
- Reset (async, takes effect immediately, no clock needed):
  - Outputs: dout=0, ack=0, dout_vld=0, gnt_id=0, busy=0.
  - Internal: state=IDLE, cnt=0, ptr=NREQ-1, so requester 0 has top priority first.
- Grant latency from IDLE: req high before edge N produces ack, dout_vld and the new dout visible after edge N.
- Write spacing: successive grants occur HOLD_CYC edges apart. Peak rate is one write per HOLD_CYC cycles.
- busy is high for exactly HOLD_CYC cycles after each grant edge.
- Reset mid-HOLD aborts the hold. dout clears to 0 and ptr resets. The first post-reset grant follows priority 0,1,...
- req and rst deasserting on the same edge: req is not sampled while rst is high.
- NREQ=1 is unsupported. HOLD_CYC=0 is a parameter error; flag it with an elaboration-time check.

## Structure
- Package dff_arb_pkg: state enum typedef (IDLE, HOLD), localparam helpers for index width.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: effective req vector, ptr.
  - Outputs: any, winner index.
  - Implement with a double-width rotate-and-priority-encode.
- Top level: FSM, counter, holding register, output registers.
- All outputs are registered.

## Test plan
- Async reset: NREQ=4, WIDTH=8, HOLD_CYC=2. After a write of 0x3C, assert rst between edges -> dout=0x00, busy=0, gnt_id=0 immediately, before the next edge.
- Single requester: req[2]=1, din[2]=0xA5, held continuously -> ack[2] and dout_vld after edges 1, 3, 5; dout=0xA5; busy high 2 cycles after each grant.
- Fairness: HOLD_CYC=1, req=4'b1111 held -> ack order 0,1,2,3,0 on consecutive edges; gnt_id follows the same sequence.
- Double-grant guard: HOLD_CYC=1, req[1]=1 dropped one cycle after ack[1] seen -> exactly one ack[1] and one dout_vld.
- Rotation: after a grant to 1, assert req[0] and req[3] together -> 3 wins, then 0 at the next eligible edge.
- Reset mid-HOLD: grant to 2, assert rst during HOLD, release with req[1] and req[3] high -> dout=0, then first grant to 1.
